program_loader: RTL and testbench

- Upstream of the single-cycle machine's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the CPU in reset until the image is complete. Once the load finishes, the machine runs the freshly loaded program.

---
 rtl/program_loader_pkg.sv | 6 +
 rtl/program_loader_byte_word_assembler.sv | 31 +++
 rtl/program_loader.sv | 109 ++++++++++
 tb/tb_program_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and width constants for the program loader.
package program_loader_pkg;
    localparam int IDX_W = 2;
    localparam int ADDR_W = 30;
    typedef enum logic [2:0] {ST_HEADER, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR} state_e;
endpackage

// File: rtl/program_loader_byte_word_assembler.sv
// program_loader_byte_word_assembler: packs handshaked bytes into big-endian 32-bit words.
module program_loader_byte_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic        ready_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [IDX_W-1:0] idx_q;
    logic [23:0]      shift_q;
    logic             xfer;

    assign xfer = valid_i && ready_i;
    assign word_valid_o = xfer && (&idx_q);
    assign word_o = {shift_q, byte_i};

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            idx_q <= '0;
            shift_q <= '0;
        end else if (xfer) begin
            idx_q <= idx_q + IDX_W'(1);
            shift_q <= {shift_q[15:0], byte_i};
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a counted word image into instruction memory, holding the CPU in reset until done.
// Optional trailing checksum word enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_WORD   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reload,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_write_enable,
    output logic [ADDR_W-1:0] imem_write_address,
    output logic [31:0]       imem_write_data,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [31:0]       words_loaded
);
    state_e            state_q, state_d;
    logic              in_ready_q, cpu_reset_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q, words_q, count_q, word;
    logic              restart, word_valid, write, check_ok;

    assign restart = reload && (state_q == ST_DONE || state_q == ST_ERROR);
    assign write = word_valid && state_q == ST_DATA;

    program_loader_byte_word_assembler u_asm (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (restart),
        .valid_i      (in_valid),
        .ready_i      (in_ready_q),
        .byte_i       (in_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e ST_LAST = ST_CHECK;
    logic [31:0] sum_q;
    assign check_ok = word == sum_q;
    always_ff @(posedge clock) begin
        if (reset || restart)
            sum_q <= '0;
        else if (write)
            sum_q <= sum_q + word;
    end
`else
    localparam state_e ST_LAST = ST_DONE;
    assign check_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (restart)
            state_d = ST_HEADER;
        else if (word_valid) begin
            if (state_q == ST_HEADER)
                state_d = word == '0 ? ST_LAST : word > 32'(DEPTH_WORDS) ? ST_ERROR : ST_DATA;
            else if (state_q == ST_DATA)
                state_d = words_q == count_q - 32'd1 ? ST_LAST : ST_DATA;
            else if (state_q == ST_CHECK)
                state_d = check_ok ? ST_DONE : ST_ERROR;
        end
    end

    // cpu_reset releases only after a full cycle in DONE, so the final strobe always precedes it
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_HEADER;
            in_ready_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            we_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            words_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            in_ready_q <= state_d inside {ST_HEADER, ST_DATA, ST_CHECK};
            cpu_reset_q <= !(state_q == ST_DONE && state_d == ST_DONE);
            we_q <= write;
            if (write) begin
                addr_q <= BASE_WORD + words_q[ADDR_W-1:0];
                data_q <= word;
            end
            if (restart)
                words_q <= '0;
            else if (write)
                words_q <= words_q + 32'd1;
            if (word_valid && state_q == ST_HEADER)
                count_q <= word;
        end
    end

    assign in_ready = in_ready_q;
    assign cpu_reset = cpu_reset_q;
    assign imem_write_enable = we_q;
    assign imem_write_address = addr_q;
    assign imem_write_data = data_q;
    assign words_loaded = words_q;
    assign load_done = state_q == ST_DONE;
    assign load_error = state_q == ST_ERROR;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table, directed and randomized image loads checked against a byte-level image model.
module tb_program_loader;
    localparam int DEPTH = 1024;
    localparam logic [29:0] BASE = 30'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, reload, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, imem_write_enable, cpu_reset, load_done, load_error;
    logic [29:0] imem_write_address;
    logic [31:0] imem_write_data, words_loaded;

    program_loader #(.DEPTH_WORDS(DEPTH), .BASE_WORD(BASE)) dut (
        .clock              (clock),
        .reset              (reset),
        .reload             (reload),
        .in_valid           (in_valid),
        .in_byte            (in_byte),
        .in_ready           (in_ready),
        .imem_write_enable  (imem_write_enable),
        .imem_write_address (imem_write_address),
        .imem_write_data    (imem_write_data),
        .cpu_reset          (cpu_reset),
        .load_done          (load_done),
        .load_error         (load_error),
        .words_loaded       (words_loaded)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int viol = 0;
    logic [61:0] strobes[$];
    logic [61:0] exp_s[$];
    logic [7:0]  img[$];
    logic        m_done, m_err;
    logic [31:0] m_words;

    always @(negedge clock) begin
        if (imem_write_enable) begin
            strobes.push_back({imem_write_address, imem_write_data});
            if (!cpu_reset) viol++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_byte = b;
        @(negedge clock);
        in_valid = 1'b0;
        in_byte = 8'($urandom);
    endtask

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[31:24]);
        img.push_back(w[23:16]);
        img.push_back(w[15:8]);
        img.push_back(w[7:0]);
    endtask

    task automatic build(input logic [31:0] n, input logic [31:0] w0, input logic [31:0] w1, input bit bad);
        logic [31:0] sum = 0;
        logic [31:0] w;
        img.delete();
        push_word(n);
        if (n > DEPTH) return;
        for (int i = 0; i < int'(n); i++) begin
            w = i == 0 ? w0 : i == 1 ? w1 : $urandom;
            push_word(w);
            sum += w;
        end
        if (CK) push_word(sum ^ {31'd0, bad});
    endtask

    function automatic logic [31:0] be(input int p);
        return {img[p], img[p+1], img[p+2], img[p+3]};
    endfunction

    task automatic model();
        logic [31:0] n, sum;
        exp_s.delete();
        n = be(0);
        sum = 0;
        m_words = 0;
        if (n > DEPTH) begin
            m_done = 0;
            m_err = 1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            exp_s.push_back({BASE + 30'(i), be(4 + 4 * i)});
            sum += be(4 + 4 * i);
        end
        m_words = n;
        if (CK) m_done = be(4 + 4 * int'(n)) == sum;
        else m_done = 1;
        m_err = !m_done;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic to_header();
        if (load_done || load_error) begin
            reload = 1'b1;
            @(negedge clock);
            reload = 1'b0;
        end
    endtask

    task automatic run(input string tag, input int gap);
        to_header();
        model();
        strobes.delete();
        foreach (img[k]) begin
            send_byte(img[k]);
            repeat (gap) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        check({tag, "_nstrobe"}, strobes.size(), exp_s.size());
        for (int k = 0; k < exp_s.size() && k < strobes.size(); k++)
            check({tag, "_strobe"}, strobes[k], exp_s[k]);
        check({tag, "_done"}, load_done, m_done);
        check({tag, "_error"}, load_error, m_err);
        check({tag, "_words"}, words_loaded, m_words);
        check({tag, "_cpu_reset"}, cpu_reset, !m_done);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        logic        done;
        logic        err;
        logic [31:0] words;
    } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{32'd2, 32'h3C010001, 32'h34210005, 0, 1'b1, 1'b0, 32'd2};
        tbl[1] = '{32'h401, 32'd0, 32'd0, 0, 1'b0, 1'b1, 32'd0};
        tbl[2] = '{32'd1, 32'hDEADBEEF, 32'd0, 1, 1'b1, 1'b0, 32'd1};
        tbl[3] = '{32'd0, 32'd0, 32'd0, 0, 1'b1, 1'b0, 32'd0};
        reset = 1'b1;
        reload = 1'b0;
        in_valid = 1'b0;
        in_byte = 8'd0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_we", imem_write_enable, 0);
        check("rst_done_err", {load_done, load_error}, 0);
        check("rst_words", words_loaded, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            build(tbl[i].n, tbl[i].w0, tbl[i].w1, 1'b0);
            run("tbl", tbl[i].gap);
            check("tbl_done_const", load_done, tbl[i].done);
            check("tbl_err_const", load_error, tbl[i].err);
            check("tbl_words_const", words_loaded, tbl[i].words);
            if (tbl[i].words != 0)
                check("tbl_first_strobe", strobes[0], {BASE, tbl[i].w0});
        end

        build(32'd2, 32'h3C010001, 32'h34210005, 1'b0);
        to_header();
        for (int k = 0; k < img.size() - 1; k++) send_byte(img[k]);
        send_byte(img[img.size() - 1]);
        check("last_strobe_cycle", imem_write_enable, !CK);
        check("done_entry", load_done, 1);
        check("cpu_reset_held_on_entry", cpu_reset, 1);
        check("words_at_done", words_loaded, 2);
        @(negedge clock);
        check("cpu_reset_release", cpu_reset, 0);
        check("no_strobe_after", imem_write_enable, 0);

        build(32'h401, 0, 0, 1'b0);
        run("err_hdr", 0);
        strobes.delete();
        in_valid = 1'b1;
        repeat (4) begin
            in_byte = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("err_no_strobe", strobes.size(), 0);
        check("err_sticky", load_error, 1);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        check("reload_ready", in_ready, 1);
        check("reload_err_clr", load_error, 0);
        check("reload_cpu_reset", cpu_reset, 1);

        build(32'd1, 32'hCAFEF00D, 0, 1'b0);
        strobes.delete();
        send_byte(img[0]);
        send_byte(img[1]);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        for (int k = 2; k < img.size(); k++) send_byte(img[k]);
        repeat (3) @(negedge clock);
        check("reload_ignored_strobe", strobes.size() > 0 ? strobes[0] : 62'd0, {BASE, 32'hCAFEF00D});
        check("reload_ignored_done", load_done, 1);

        to_header();
        build(32'd1, 32'hAABBCCDD, 0, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(img[k]);
        reset = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hCC;
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b0;
        check("midrst_ready", in_ready, 1);
        check("midrst_cpu_reset", cpu_reset, 1);
        check("midrst_addr_data", {imem_write_address, imem_write_data}, 0);
        check("midrst_words", words_loaded, 0);
        build(32'd1, 32'h11223344, 0, 1'b0);
        run("midrst_img", 0);
        check("midrst_strobe", strobes.size() > 0 ? strobes[0] : 62'd0, {BASE, 32'h11223344});

        to_header();
        img.delete();
        push_word(DEPTH);
        foreach (img[k]) send_byte(img[k]);
        @(negedge clock);
        check("depth_edge_err", load_error, 0);
        check("depth_edge_ready", in_ready, 1);
        do_reset();

        build(32'd2, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        run("ck_good", 0);
        check("ck_good_done", load_done, 1);
        build(32'd2, 32'h00000001, 32'hFFFFFFFF, 1'b1);
        run("ck_bad", 0);
        check("ck_bad_err", load_error, CK);
        check("ck_bad_cpu_reset", cpu_reset, CK);

        for (int r = 0; r < 30; r++) begin
            logic [31:0] n;
            n = ($urandom % 8 == 0) ? 32'(DEPTH + 1 + $urandom % 100) : 32'($urandom_range(0, 6));
            if ($urandom % 5 == 0) do_reset();
            build(n, $urandom, $urandom, $urandom % 4 == 0);
            run("rnd", $urandom_range(0, 2));
        end

        check("strobe_before_release", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
